mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register. Consumes address, store data and control from EX/MEM; produces `data_from_mem` for MEM/WB.
- Drives a multi-cycle data-memory bus with a req/ready handshake.
- Stalls the pipeline while a transfer is outstanding, and kills the MEM/WB write-enable during stall cycles, because MEM/WB loads every cycle.

Parameters:
- TIMEOUT, 16: max cycles `dmem_req` may stay high without `dmem_ready` before abort.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- alu_result  in  32  effective byte address from EX/MEM
- write_data  in  32  store data (rt) from EX/MEM
- mem_read  in  1  load in MEM stage
- mem_write  in  1  store in MEM stage
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  bus write, registered
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_be  out  4  byte enables, registered
- dmem_ready  in  1  bus completes the transfer this cycle
- dmem_rdata  in  32  read word, valid when `dmem_ready`=1
- data_from_mem  out  32  extended load result to MEM/WB `data_from_mem_pl`
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (ld_en low); combinational
- wb_we_kill  out  1  force MEM/WB `we_pl` to 0 this cycle; combinational
- misalign  out  1  misaligned access detected this cycle; combinational
- bus_error  out  1  sticky; timeout occurred; cleared only by `rst`

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_be`=0, captured data=0, counter=0, `bus_error`=0.
- Combinational outputs under reset: `stall`=0, `wb_we_kill`=0, `misalign`=0.
- `op` = `mem_read` | `mem_write`. If both are 1, the access is a store and `data_from_mem`=0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - `misalign`=1, `wb_we_kill`=1, `stall`=0.
  - No bus request; state stays IDLE.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `op` and aligned: `stall`=1, `wb_we_kill`=1. Register the bus fields and set `dmem_req`=1, `dmem_we`=`mem_write`. Next state BUSY, counter=0.
  - Otherwise `stall`=0, `wb_we_kill`=0.
- BUSY:
  - `stall`=1, `wb_we_kill`=1, `dmem_req` held at 1.
  - All bus outputs are stable until `dmem_ready`.
  - On `dmem_ready`=1: `dmem_req`←0, capture the extended `dmem_rdata` (loads), next state DONE.
  - Else if counter=TIMEOUT-1: `dmem_req`←0, `bus_error`←1, captured data←0, next state DONE.
  - Else counter+1.
- DONE:
  - `stall`=0, `wb_we_kill`=0, `data_from_mem`=captured value.
  - The pipeline advances this cycle; next state IDLE.
  - A following memory op therefore appears in the next cycle in IDLE.
- Latency: a zero-wait access (`dmem_ready` in the first BUSY cycle) holds the instruction in MEM for 3 cycles; each wait cycle adds 1.
- Byte enables and store replication:
  - byte: be = 0001 << addr[1:0], wdata = {4{wd[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - word: be = 1111, wdata = wd.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign- or zero-extend per `mem_unsigned`. Word loads pass through.
- `data_from_mem` is 0 in every cycle that is not DONE.
- Reset mid-transfer: return to IDLE on the same edge. `dmem_req` drops; the in-flight transaction is abandoned.
- `dmem_ready` asserted while not BUSY is ignored.
- Inputs are held stable by the stall throughout BUSY; changes in BUSY are ignored (the registered copy is used).

Test Plan:
1. `lw` at addr 0x0000_0010, `dmem_ready` on 1st BUSY cycle, rdata 0xDEADBEEF.
   - Expect `stall`=1 for 2 cycles, then DONE with `data_from_mem`=0xDEADBEEF.
   - Expect `dmem_addr`=0x10, `dmem_be`=1111.
2. `lb` at addr 0x13, rdata 0x80FF_0000, signed.
   - Expect `data_from_mem`=0xFFFF_FF80.
   - Same access with `lbu`: expect 0x0000_0080.
3. `sh` addr 0x22, `write_data`=0x1234_ABCD, 3 wait cycles.
   - Expect `dmem_be`=1100, `dmem_wdata`=0xABCD_ABCD, `dmem_we`=1.
   - Expect `stall` high for 5 cycles and `wb_we_kill` high for the same 5 cycles.
4. `lw` addr 0x06.
   - Expect `misalign`=1, `wb_we_kill`=1, `stall`=0, `dmem_req` never asserted.
5. `lw` with `dmem_ready` held 0, TIMEOUT=16.
   - Expect `dmem_req` high for exactly 16 cycles.
   - Then `bus_error`=1 (sticky), DONE with `data_from_mem`=0.
6. `rst` asserted in the 2nd BUSY cycle.
   - Expect `dmem_req`=0, `stall`=0 next cycle.
   - A new `sw` is then accepted normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: launches one bus transfer per load/store,
// stalls the pipeline until it completes or times out, and extends load data.
//
// state | meaning
// IDLE  | waiting for a load/store in MEM; accepts it in the same cycle
// BUSY  | request outstanding on the bus, pipeline frozen
// DONE  | transfer finished, result presented, pipeline advances
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         alu_result_i,
    input  logic [31:0]         write_data_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [1:0]          mem_size_i,
    input  logic                mem_unsigned_i,
    mem_access_stage_if.master  dmem,
    output logic [31:0]         data_from_mem_o,
    output logic                stall_o,
    output logic                wb_we_kill_o,
    output logic                misalign_o,
    output logic                bus_error_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic               req_q, we_q, berr_q;
    logic [31:0]        addr_q, wdata_q, data_q;
    logic [3:0]         be_q;
    logic [1:0]         size_q, lane_q;
    logic               uns_q, load_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               op, misaligned, accept;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d, load_ext;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    // Alignment check, byte enables and lane replication for the incoming access.
    always_comb begin
        op         = mem_read_i | mem_write_i;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = write_data_i;
        case (mem_size_i)
            2'b00: begin
                be_d    = 4'b0001 << alu_result_i[1:0];
                wdata_d = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result_i[0];
                be_d       = alu_result_i[1] ? 4'b1100 : 4'b0011;
                wdata_d    = {2{write_data_i[15:0]}};
            end
            default: misaligned = |alu_result_i[1:0];
        endcase
        accept = (state_q == IDLE) && op && !misaligned;
    end

    // Lane extraction and extension of the returned word, using the registered access.
    always_comb begin
        byte_sel = dmem.dmem_rdata[8*lane_q +: 8];
        half_sel = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Sequencer: capture the access, hold the request, finish on ready or timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            lane_q  <= '0;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_write_i;
                        addr_q  <= {alu_result_i[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        size_q  <= mem_size_i;
                        lane_q  <= alu_result_i[1:0];
                        uns_q   <= mem_unsigned_i;
                        load_q  <= mem_read_i & ~mem_write_i;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ready) begin
                        req_q   <= 1'b0;
                        data_q  <= load_q ? load_ext : 32'h0;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        berr_q  <= 1'b1;
                        data_q  <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pipeline control is combinational so the freeze takes effect in the accept cycle.
    always_comb begin
        misalign_o      = !rst && (state_q == IDLE) && op && misaligned;
        stall_o         = !rst && (accept || (state_q == BUSY));
        wb_we_kill_o    = stall_o || misalign_o;
        data_from_mem_o = (state_q == DONE) ? data_q : 32'h0;
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign bus_error_o     = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model expands each
// access into the per-cycle outputs it must produce; one process compares them.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, write_data;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] data_from_mem;
    logic        stall, wb_we_kill, misalign, bus_error;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_result_i    (alu_result),
        .write_data_i    (write_data),
        .mem_read_i      (mem_read),
        .mem_write_i     (mem_write),
        .mem_size_i      (mem_size),
        .mem_unsigned_i  (mem_unsigned),
        .dmem            (bus),
        .data_from_mem_o (data_from_mem),
        .stall_o         (stall),
        .wb_we_kill_o    (wb_we_kill),
        .misalign_o      (misalign),
        .bus_error_o     (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall, kill, mis, req, we, chk_bus, done, pin, berr;
        logic [31:0] addr, wdata, dfm, pin_dfm, pin_wd;
        logic [3:0]  be, pin_be;
        int          pin_stall;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_run = 0;
    bit   berr_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model entry for this cycle, away from the rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("wb_we_kill", 32'(wb_we_kill), 32'(e.kill));
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("dmem_req", 32'(bus.dmem_req), 32'(e.req));
            chk("bus_error", 32'(bus_error), 32'(e.berr));
            chk("data_from_mem", data_from_mem, e.dfm);
            if (e.chk_bus) begin
                chk("dmem_we", 32'(bus.dmem_we), 32'(e.we));
                chk("dmem_addr", bus.dmem_addr, e.addr);
                chk("dmem_wdata", bus.dmem_wdata, e.wdata);
                chk("dmem_be", 32'(bus.dmem_be), 32'(e.be));
                if (e.pin) begin
                    chk("pin_be", 32'(bus.dmem_be), 32'(e.pin_be));
                    chk("pin_wdata", bus.dmem_wdata, e.pin_wd);
                end
            end
            if (stall) stall_run++;
            else if (!e.done) stall_run = 0;
            if (e.done) begin
                if (e.pin) begin
                    chk("pin_data", data_from_mem, e.pin_dfm);
                    chk("pin_stall_cycles", 32'(stall_run), 32'(e.pin_stall));
                end
                stall_run = 0;
            end
        end
    end

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'd0) return 4'(1 << a[1:0]);
        if (size == 2'd1) return a[1] ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '{default: '0};
        e.berr = berr_m;
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        mem_read = 0; mem_write = 0; mem_size = 2'd0; mem_unsigned = 0;
        alu_result = 32'h0; write_data = 32'h0;
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                          input int waits, input bit pin, input logic [31:0] pin_dfm,
                          input logic [3:0] pin_be, input logic [31:0] pin_wd, input int pin_stall);
        exp_t e;
        bit   mis, tmo;
        int   nb;
        mis = (size == 2'd1 && a[0]) || (size >= 2'd2 && a[1:0] != 2'd0);
        mem_read = rd; mem_write = wr; mem_size = size; mem_unsigned = uns;
        alu_result = a; write_data = wd;
        bus.dmem_ready = 0;
        if (mis) begin
            e = base(); e.kill = 1; e.mis = 1;
            cyc(e);
            nop();
            e = base();
            cyc(e);
            return;
        end
        e = base(); e.stall = 1; e.kill = 1;
        cyc(e);
        tmo = (waits >= TIMEOUT);
        nb  = tmo ? TIMEOUT : waits + 1;
        for (int i = 0; i < nb; i++) begin
            bus.dmem_rdata = rdata;
            bus.dmem_ready = (i == waits);
            e = base(); e.stall = 1; e.kill = 1; e.req = 1; e.chk_bus = 1;
            e.we = wr; e.addr = a & ~32'd3; e.wdata = m_wd(size, wd); e.be = m_be(size, a);
            e.pin = pin; e.pin_be = pin_be; e.pin_wd = pin_wd;
            cyc(e);
        end
        bus.dmem_ready = 0;
        bus.dmem_rdata = 32'h5A5A_5A5A;
        if (tmo) berr_m = 1'b1;
        e = base(); e.done = 1;
        e.dfm = (tmo || wr) ? 32'h0 : m_load(size, uns, a, rdata);
        e.pin = pin; e.pin_dfm = pin_dfm; e.pin_stall = pin_stall;
        cyc(e);
        nop();
        e = base();
        cyc(e);
    endtask

    initial begin
        exp_t e;
        rst = 1; nop();
        bus.dmem_ready = 0; bus.dmem_rdata = 32'h0;
        @(posedge clk); #1;
        e = base();
        cyc(e);
        cyc(e);
        rst = 0;
        cyc(e);

        // lw zero-wait
        run_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 2);
        // lb / lbu at lane 3
        run_op(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80, 4'b1000, 32'h0, 2);
        run_op(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF_0000, 1, 1, 32'h0000_0080, 4'b1000, 32'h0, 3);
        // sh with 3 wait cycles
        run_op(0, 1, 2'd1, 0, 32'h22, 32'h1234_ABCD, 32'hFFFF_FFFF, 3, 1, 32'h0, 4'b1100, 32'hABCD_ABCD, 5);
        // lh signed upper half, sb lane 1, reserved size as word, read+write as store
        run_op(1, 0, 2'd1, 0, 32'h22, 32'h0, 32'h8001_1234, 2, 1, 32'hFFFF_8001, 4'b1100, 32'h0, 4);
        run_op(1, 0, 2'd1, 1, 32'h20, 32'h0, 32'h8001_9234, 0, 1, 32'h0000_9234, 4'b0011, 32'h0, 2);
        run_op(0, 1, 2'd0, 0, 32'h01, 32'hAB55, 32'h0, 0, 1, 32'h0, 4'b0010, 32'h5555_5555, 2);
        run_op(1, 0, 2'd3, 0, 32'h1C, 32'h0, 32'h0123_4567, 1, 1, 32'h0123_4567, 4'b1111, 32'h0, 3);
        run_op(1, 1, 2'd2, 0, 32'h30, 32'hCAFE_F00D, 32'h1111_1111, 0, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 2);
        // misaligned accesses
        run_op(1, 0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        run_op(0, 1, 2'd1, 0, 32'h21, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);

        // ready while idle is ignored
        bus.dmem_ready = 1; bus.dmem_rdata = 32'hFFFF_FFFF;
        e = base();
        cyc(e);
        cyc(e);
        bus.dmem_ready = 0;

        // timeout: 16 request cycles, then sticky bus_error
        run_op(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h7777_7777, 99, 1, 32'h0, 4'b1111, 32'h0, 17);
        run_op(1, 0, 2'd2, 0, 32'h44, 32'h0, 32'h2468_ACE0, 0, 1, 32'h2468_ACE0, 4'b1111, 32'h0, 2);

        // reset in the second BUSY cycle
        mem_read = 1; mem_size = 2'd2; alu_result = 32'h50;
        e = base(); e.stall = 1; e.kill = 1;
        cyc(e);
        e = base(); e.stall = 1; e.kill = 1; e.req = 1;
        cyc(e);
        rst = 1; nop();
        e = base(); e.req = 1;
        cyc(e);
        berr_m = 1'b0;
        rst = 0;
        e = base();
        cyc(e);
        run_op(0, 1, 2'd2, 0, 32'h54, 32'h0BAD_F00D, 32'h0, 1, 1, 32'h0, 4'b1111, 32'h0BAD_F00D, 3);

        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
